// File: rtl/clock_monitor.sv
// Clock monitor: measures high/low phases of a sampled clock, checks bounds, tracks lock and stuck errors.
// Optional duty-cycle check is compiled in with `define CLOCKMON_DUTY_CHECK_EN.
module clock_monitor #(
    parameter int CNT_W      = 16,
    parameter int HIGH_MIN   = 3,
    parameter int HIGH_MAX   = 5,
    parameter int LOW_MIN    = 3,
    parameter int LOW_MAX    = 5,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64
`ifdef CLOCKMON_DUTY_CHECK_EN
    ,
    parameter int DUTY_TOL   = 1
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             mon_in,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_high,
    output logic             err_low,
    output logic             err_stuck,
`ifdef CLOCKMON_DUTY_CHECK_EN
    output logic             err_duty,
`endif
    output logic [7:0]       err_count
);

    // state     | meaning
    // IDLE      | monitor disabled, outputs hold
    // ALIGN     | waiting for a rising edge to start a clean period
    // MEAS_HIGH | counting the high phase
    // MEAS_LOW  | counting the low phase
    typedef enum logic [1:0] {IDLE, ALIGN, MEAS_HIGH, MEAS_LOW} state_t;

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_N  = RUN_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_MIN   = CNT_W'(HIGH_MIN);
    localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0] L_MIN   = CNT_W'(LOW_MIN);
    localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(LOW_MAX);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

    state_t             state, state_n;
    logic               sync1, s, s_d;
    logic               rise, fall;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [RUN_W-1:0]   good_run, good_run_n;
    logic               high_ok, high_ok_n;
    logic [CNT_W-1:0]   high_len_n, low_len_n;
    logic               meas_valid_n, locked_n;
    logic               err_high_n, err_low_n, err_stuck_n;
    logic [7:0]         err_count_n;
    logic               duty_ok, high_in, low_in, timeout;
`ifdef CLOCKMON_DUTY_CHECK_EN
    logic               err_duty_n;
    logic [CNT_W-1:0]   duty_diff;
`endif

    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign timeout = (cnt == TO_CNT);
    assign high_in = (cnt >= H_MIN) && (cnt <= H_MAX);
    assign low_in  = (cnt >= L_MIN) && (cnt <= L_MAX);

`ifdef CLOCKMON_DUTY_CHECK_EN
    // In MEAS_LOW, cnt is the low length of the period being closed.
    assign duty_diff = (high_len > cnt) ? high_len - cnt : cnt - high_len;
    assign duty_ok   = (duty_diff <= CNT_W'(DUTY_TOL));
`else
    assign duty_ok   = 1'b1;
`endif

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        good_run_n   = good_run;
        high_ok_n    = high_ok;
        high_len_n   = high_len;
        low_len_n    = low_len;
        meas_valid_n = 1'b0;
        locked_n     = locked;
        err_high_n   = err_high;
        err_low_n    = err_low;
        err_stuck_n  = err_stuck;
        err_count_n  = err_count;
`ifdef CLOCKMON_DUTY_CHECK_EN
        err_duty_n   = err_duty;
`endif

        if (!enable) begin
            state_n    = IDLE;
            locked_n   = 1'b0;
            good_run_n = '0;
        end else begin
            case (state)
                IDLE: state_n = ALIGN;
                ALIGN: begin
                    if (rise) begin
                        cnt_n   = CNT_W'(1);
                        state_n = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_len_n = cnt;
                        high_ok_n  = high_in;
                        if (!high_in) err_high_n = 1'b1;
                        cnt_n   = CNT_W'(1);
                        state_n = MEAS_LOW;
                    end else if (timeout) begin
                        err_stuck_n = 1'b1;
                        err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                        locked_n    = 1'b0;
                        good_run_n  = '0;
                        state_n     = ALIGN;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        low_len_n    = cnt;
                        meas_valid_n = 1'b1;
                        cnt_n        = CNT_W'(1);
                        state_n      = MEAS_HIGH;
                        if (!low_in) err_low_n = 1'b1;
`ifdef CLOCKMON_DUTY_CHECK_EN
                        if (!duty_ok) err_duty_n = 1'b1;
`endif
                        if (high_ok && low_in && duty_ok) begin
                            good_run_n = (good_run == LOCK_N) ? LOCK_N : good_run + RUN_W'(1);
                            locked_n   = (good_run_n == LOCK_N);
                        end else begin
                            err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                            good_run_n  = '0;
                            locked_n    = 1'b0;
                        end
                    end else if (timeout) begin
                        err_stuck_n = 1'b1;
                        err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                        locked_n    = 1'b0;
                        good_run_n  = '0;
                        state_n     = ALIGN;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // clear wins over any error raised in the same cycle
        if (clear) begin
            err_high_n  = 1'b0;
            err_low_n   = 1'b0;
            err_stuck_n = 1'b0;
            err_count_n = '0;
`ifdef CLOCKMON_DUTY_CHECK_EN
            err_duty_n  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            s          <= 1'b0;
            s_d        <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            good_run   <= '0;
            high_ok    <= 1'b0;
            high_len   <= '0;
            low_len    <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err_high   <= 1'b0;
            err_low    <= 1'b0;
            err_stuck  <= 1'b0;
            err_count  <= '0;
`ifdef CLOCKMON_DUTY_CHECK_EN
            err_duty   <= 1'b0;
`endif
        end else begin
            sync1      <= mon_in;
            s          <= sync1;
            s_d        <= s;
            state      <= state_n;
            cnt        <= cnt_n;
            good_run   <= good_run_n;
            high_ok    <= high_ok_n;
            high_len   <= high_len_n;
            low_len    <= low_len_n;
            meas_valid <= meas_valid_n;
            locked     <= locked_n;
            err_high   <= err_high_n;
            err_low    <= err_low_n;
            err_stuck  <= err_stuck_n;
            err_count  <= err_count_n;
`ifdef CLOCKMON_DUTY_CHECK_EN
            err_duty   <= err_duty_n;
`endif
        end
    end

endmodule
